// File: rtl/a_dmx_stim_param.sv
// Packs RATIO stimulus words into one DUT word; r_incr_o requests, capture one cycle later, r_o/r_dv_o
// update on the edge that captures the last slot. stop_i pauses requests without losing in-flight words.
module a_dmx_stim_param #(
    parameter int IN_W  = 64,
    parameter int RATIO = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk_ref,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic                  start_verif_i,
    input  logic                  egal_clk_ref_i,
    input  logic                  stop_i,
    input  logic [IN_W-1:0]       stimu_i,
    output logic                  r_incr_o,
    output logic [IN_W*RATIO-1:0] r_o,
    output logic                  r_dv_o,
    output logic [CNT_W-1:0]      r_nb_word_o
);

    localparam int SLOT_W = $clog2(RATIO + 1);
    localparam logic [SLOT_W-1:0] RATIO_C   = SLOT_W'(RATIO);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

    typedef enum logic [1:0] {IDLE, GATHER, PAUSE} state_t;

    state_t                  state;
    logic                    cap_en;
    logic                    egal_q;
    logic [SLOT_W-1:0]       req_cnt;
    logic [SLOT_W-1:0]       cap_slot;
    logic [SLOT_W-1:0]       req_nxt;
    logic [IN_W*RATIO-1:0]   shadow;

    always_comb begin
        req_nxt = r_incr_o ? req_cnt + 1'b1 : req_cnt;
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state       <= IDLE;
            r_incr_o    <= 1'b0;
            r_dv_o      <= 1'b0;
            r_o         <= '0;
            r_nb_word_o <= '0;
            cap_en      <= 1'b0;
            egal_q      <= 1'b0;
            req_cnt     <= '0;
            cap_slot    <= '0;
            shadow      <= '0;
        end else begin
            cap_en <= r_incr_o;
            r_dv_o <= 1'b0;

            if (cap_en) begin
                if (cap_slot == LAST_SLOT) begin
                    r_o                              <= shadow;
                    r_o[(RATIO-1)*IN_W +: IN_W]      <= stimu_i;
                    r_dv_o                           <= 1'b1;
                    r_nb_word_o                      <= r_nb_word_o + 1'b1;
                    cap_slot                         <= '0;
                end else begin
                    shadow[cap_slot*IN_W +: IN_W]    <= stimu_i;
                    cap_slot                         <= cap_slot + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (!stop_i && (egal_clk_ref_i ? start_verif_i : run_i)) begin
                        state    <= GATHER;
                        r_incr_o <= 1'b1;
                        req_cnt  <= '0;
                        cap_slot <= '0;
                        egal_q   <= egal_clk_ref_i;
                    end
                end
                GATHER: begin
                    req_cnt <= req_nxt;
                    if (stop_i) begin
                        r_incr_o <= 1'b0;
                        state    <= PAUSE;
                    end else if (!r_incr_o) begin
                        // all requests issued; the final capture lands on this edge
                        state <= IDLE;
                    end else if (req_nxt == RATIO_C) begin
                        if (!egal_q && run_i) begin
                            req_cnt <= '0;
                        end else begin
                            r_incr_o <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (!stop_i) begin
                        if (req_cnt == RATIO_C) begin
                            state <= IDLE;
                        end else begin
                            state    <= GATHER;
                            r_incr_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
